// File: rtl/spi_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_aes_pkg
// Purpose  : Shared types and constants for the SPI-side AES slave sequencer.
// Revision : 1.0  initial release
// ============================================================================
package spi_aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_MSG  = 3'd2,
    ST_GAP  = 3'd3,
    ST_KEY  = 3'd4,
    ST_READ = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic [1:0] SZ128  = 2'b00;
  localparam logic [1:0] SZ192  = 2'b01;
  localparam logic [1:0] SZ256  = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  // One dummy bit precedes the 128 message bits; read-back discards its first sample
  localparam int unsigned MSG_PHASE_LEN  = 129;
  localparam int unsigned READ_PHASE_LEN = 129;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_READ = 1'b1;

  // Key length in bits (Nk*32) for a legal size code
  function automatic logic [8:0] nk_bits(input logic [1:0] size);
    case (size)
      SZ128:   nk_bits = 9'd128;
      SZ192:   nk_bits = 9'd192;
      SZ256:   nk_bits = 9'd256;
      default: nk_bits = 9'd128;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_aes_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_aes_shifter
// Purpose  : Phase bit counter, msg/key serializer onto simo and somi
//            deserializer into the result register.
// Revision : 1.0  initial release
// ============================================================================
module spi_aes_shifter
  import spi_aes_pkg::*;
#(
  parameter int MSG_W = 128,
  parameter int KEY_W = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  state_e           state_q,
  input  state_e           state_d,
  input  logic [CNT_W-1:0] phase_last,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [KEY_W-1:0] key_in,
  input  logic             somi,
  output logic [CNT_W-1:0] cnt,
  output logic             simo,
  output logic [MSG_W-1:0] result
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MSG_W-1:0] msg_q, msg_d, result_q, result_d, msg_sh, bit_mask;
  logic [KEY_W-1:0] key_q, key_d, key_sh;
  logic             simo_q, simo_d;

  // Counter restarts on every state change and holds at the last bit of a phase
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == phase_last) begin
      cnt_d = cnt_q;
    end
  end

  // Latch the job data and pick the next simo bit for the upcoming cycle
  always_comb begin
    msg_d  = load ? msg_in : msg_q;
    key_d  = load ? key_in : key_q;
    msg_sh = msg_q >> (cnt_d - CNT_W'(1));
    key_sh = key_q >> cnt_d;
    simo_d = 1'b0;
    case (state_d)
      ST_MSG:  simo_d = (cnt_d != '0) ? msg_sh[0] : 1'b0;
      ST_KEY:  simo_d = key_sh[0];
      default: simo_d = 1'b0;
    endcase
  end

  // Read-back sample k (k>=1) lands in result bit k-1; sample 0 is dropped
  always_comb begin
    bit_mask = MSG_W'(1) << (cnt_q - CNT_W'(1));
    result_d = result_q;
    if (load) begin
      result_d = '0;
    end else if ((state_q == ST_READ) && (cnt_q != '0)) begin
      result_d = somi ? (result_q | bit_mask) : (result_q & ~bit_mask);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      msg_q    <= '0;
      key_q    <= '0;
      result_q <= '0;
      simo_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
      result_q <= result_d;
      simo_q   <= simo_d;
    end
  end

  assign cnt    = cnt_q;
  assign simo   = simo_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: rtl/spi_aes_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_aes_master
// Purpose  : Host-side job sequencer for the serial AES slave: loads message
//            and key over SPI, switches to read-back, returns the result.
// Revision : 1.0  initial release
// ============================================================================
module spi_aes_master
  import spi_aes_pkg::*;
#(
  parameter int MSG_W = 128,
  parameter int KEY_W = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       size_in,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [MSG_W-1:0] result,
  output logic             slv_rst,
  output logic             css,
  output logic             simo,
  output logic             mode,
  output logic [1:0]       size,
  input  logic             somi
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, phase_last;
  logic             accept, phase_end;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             slv_rst_q, slv_rst_d, css_q, css_d, mode_q, mode_d;
  logic [1:0]       size_q, size_d;

  assign accept    = (state_q == ST_IDLE) && start && (size_in != SZ_BAD);
  assign phase_end = (cnt_q == phase_last);

  // Last counter value of the current phase
  always_comb begin
    phase_last = '0;
    case (state_q)
      ST_MSG:  phase_last = CNT_W'(MSG_PHASE_LEN - 1);
      ST_KEY:  phase_last = CNT_W'(nk_bits(size_q) - 9'd1);
      ST_READ: phase_last = CNT_W'(READ_PHASE_LEN - 1);
      default: phase_last = '0;
    endcase
  end

  // Next state, then registered pin values derived from the state being entered
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PREP;
      ST_PREP: state_d = ST_MSG;
      ST_MSG:  if (phase_end) state_d = ST_GAP;
      ST_GAP:  state_d = ST_KEY;
      ST_KEY:  if (phase_end) state_d = ST_READ;
      ST_READ: if (phase_end) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    css_d     = (state_d == ST_IDLE) || (state_d == ST_PREP) || (state_d == ST_DONE);
    slv_rst_d = (state_d == ST_PREP);
    mode_d    = (state_d == ST_READ) ? MODE_READ : MODE_LOAD;
    done_d    = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    err_d     = (state_q == ST_IDLE) && start && (size_in == SZ_BAD);
    size_d    = accept ? size_in : size_q;
  end

  // Control state and pin registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      css_q     <= 1'b1;
      slv_rst_q <= 1'b0;
      mode_q    <= MODE_LOAD;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ128;
    end else begin
      state_q   <= state_d;
      css_q     <= css_d;
      slv_rst_q <= slv_rst_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      size_q    <= size_d;
    end
  end

  spi_aes_shifter #(
    .MSG_W(MSG_W),
    .KEY_W(KEY_W),
    .CNT_W(CNT_W)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .state_q   (state_q),
    .state_d   (state_d),
    .phase_last(phase_last),
    .msg_in    (msg_in),
    .key_in    (key_in),
    .somi      (somi),
    .cnt       (cnt_q),
    .simo      (simo),
    .result    (result)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign slv_rst = slv_rst_q;
  assign css     = css_q;
  assign mode    = mode_q;
  assign size    = size_q;

endmodule
`default_nettype wire

// File: doc/spi_aes_master.md
Name: spi_aes_master

Overview:
SPI-side sequencer for the serial AES slave. It latches one message/key/size job from the host, shifts the message and key into the slave, and switches the slave to read-back mode. It then collects the 128-bit result from SOMI and returns it with a done pulse. It sits between the host register interface and the Slave/AES pair, and owns every slave control pin.

Parameters:
MSG_W, 128, message and result width in bits
KEY_W, 256, maximum key width in bits (Nk=8)
CNT_W, 9, phase bit-counter width; must hold 0..KEY_W

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle job request; sampled only in IDLE
size_in  in  2  key size: 00=128, 01=192, 10=256, 11=illegal
msg_in  in  MSG_W  message; latched on an accepted start
key_in  in  KEY_W  key, LSB-aligned; latched on an accepted start
busy  out  1  high from an accepted start until done
done  out  1  one-cycle pulse when result is valid
err  out  1  one-cycle pulse when a start with size_in=11 is rejected
result  out  MSG_W  captured read-back; held until the next accepted start
slv_rst  out  1  active-high reset to the slave
css  out  1  chip select, active-low
simo  out  1  serial data to the slave
mode  out  1  0=load (encrypt path), 1=read-back
size  out  2  registered copy of the latched size
somi  in  1  serial data from the slave

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - css=1, slv_rst=0, simo=0, mode=0, size=00.
  - busy=0, done=0, err=0, result=0, counter=0.
- Clock and reset are fixed: one clock domain (clk), asynchronous active-low reset (reset).
- Nk = 4/6/8 for size 00/01/10. key_bits = Nk*32 (128/192/256).
- States:
  - IDLE: css=1.
    - start & size_in!=11: latch msg, key and size; clear result; busy=1; go to PREP.
    - start & size_in==11: err=1 for one cycle; stay in IDLE; busy stays 0.
  - PREP (1 cycle): slv_rst=1, css=1, mode=0. Counter is cleared. Next state is MSG.
  - MSG (129 cycles, cnt 0..128): css=0, mode=0.
    - cnt=0: simo=0 (dummy bit, discarded by the slave shift).
    - cnt=k (1..128): simo=msg[k-1], LSB first.
    - After cnt=128, go to GAP.
  - GAP (1 cycle): css=0, mode=0, simo=0. Next state is KEY.
  - KEY (key_bits cycles, cnt 0..key_bits-1): css=0, mode=0, simo=key[cnt]. Next state is READ.
  - READ (129 cycles, cnt 0..128): css=0, mode=1.
    - The slave registers decrypt[j] at READ cycle j.
    - The controller samples somi at the posedge ending each cycle cnt=1..128 into result[cnt-1].
    - The sample at cnt=0 is discarded.
  - DONE (1 cycle): css=1, mode=0, done=1, busy=0. Next state is IDLE.
- Latency from the accepted-start edge to the done pulse: 1+129+1+key_bits+129+1 cycles.
  - 389 cycles for size 00.
  - 453 cycles for size 01.
  - 517 cycles for size 10.
- All SPI outputs are registered. simo changes only on the clk rising edge.
- start outside IDLE is ignored, with no queueing. start in the same cycle as DONE is ignored; it is accepted from IDLE on the next cycle.
- Host inputs are not looked at after latching. Changing msg_in, key_in or size_in mid-job has no effect.
- Reset mid-job aborts immediately: css=1, result=0, no done pulse.
- The counter saturates at phase end and wraps to 0 on each state change. It never exceeds KEY_W.

Decomposition:
- Shared package spi_aes_pkg:
  - state encoding: IDLE, PREP, MSG, GAP, KEY, READ, DONE
  - size codes SZ128=00, SZ192=01, SZ256=10
  - MSG_PHASE_LEN=129, READ_PHASE_LEN=129
  - mode codes MODE_LOAD=0, MODE_READ=1
  - function nk_bits(size) returning 128/192/256
- Sub-module: spi_aes_shifter. It holds the bit counter, the output serializer (msg/key mux onto simo) and the input deserializer (somi into result). The top level keeps the FSM and the handshake.

Test Plan:
- Reset then idle: reset=0 for 3 cycles then 1, no start -> css=1, busy=0, done=0, result=0 for 20 cycles.
- AES-128 job:
  - stimulus: start, size_in=00, msg=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f; bench slave model drives SOMI with a known 128-bit pattern.
  - check simo bitstream: dummy 0, then msg LSB first, GAP 0, then 128 key bits.
  - check timing and result: done exactly 389 cycles after start; result equals the driven pattern.
- Key-size sweep: size_in=01 and 10 with key=00..1f -> KEY phase lasts 192/256 cycles; done at 453/517; size output matches size_in.
- Illegal size: start, size_in=11 -> err pulse one cycle, busy=0, css stays 1, no slv_rst.
- start ignored while busy: second start at cycle 50 with a different msg -> the first job completes with its original data; exactly one done pulse.
- Reset mid-operation: reset=0 during KEY cycle 40 -> css=1 asynchronously, state IDLE, no done; a following job completes normally.
